// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: HI/LO register pair plus a shared 32-step shift/add and
// restoring-divide datapath for signed MULT/DIV. A second path handles MTHI/MTLO.
// The datapath works on operand magnitudes. The FIX state applies the result signs
// and writes HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    // Datapath state: mag holds the multiplicand or divisor, sh holds the
    // multiplier or dividend. sh is consumed MSB first.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               neg_q, neg_d;
    logic               sa_q, sa_d;
    logic               is_div_q, is_div_d;

    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Two's-complement magnitude. The most negative value maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = (v < 0) ? WIDTH'(-v) : WIDTH'(v);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // One iteration of each datapath plus the sign fix-up of the final result
    always_comb begin
        mul_next = {acc_q[2*WIDTH-2:0], 1'b0} +
                   (sh_q[WIDTH-1] ? {{WIDTH{1'b0}}, mag_q} : {(2*WIDTH){1'b0}});
        rem_sh   = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, mag_q};
        div_ge   = ~trial[WIDTH];
        div_next = {acc_q[2*WIDTH-2:WIDTH], div_ge,
                    div_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]};
        prod_fix = cond_neg_2w(neg_q, acc_q);
        quot_fix = cond_neg_w(neg_q, acc_q[2*WIDTH-1:WIDTH]);
        rem_fix  = cond_neg_w(sa_q, acc_q[WIDTH-1:0]);
    end

    // Next-state, operand capture and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = 1'b0;
        acc_d    = acc_q;
        mag_d    = mag_q;
        sh_d     = sh_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        is_div_d = is_div_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
                if (start) begin
                    sa_d     = a[WIDTH-1];
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    is_div_d = op;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (op) begin
                        mag_d = abs_val(b);
                        sh_d  = abs_val(a);
                        if (b == '0) begin
                            state_d = S_DONE;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
                        mag_d   = abs_val(a);
                        sh_d    = abs_val(b);
                        state_d = S_MUL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                cnt_d   = '0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural HI/LO registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Datapath registers; these are always reloaded before use, so no reset
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mag_q    <= mag_d;
        sh_q     <= sh_d;
        neg_q    <= neg_d;
        sa_q     <= sa_d;
        is_div_q <= is_div_d;
    end

    assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer. It uses a result scoreboard, a table of
// directed vectors, randomized vectors from a behavioural model, and
// hand-written multi-cycle sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[10];

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint px, py;
        int     sx, sy;
        if (!o) begin
            px = $signed(x);
            py = $signed(y);
            return 64'(px * py);
        end
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    // Scoreboard: each done pulse pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = sb_q.pop_front();
                chk("sb_hi", {32'h0, hi_out}, {32'h0, e.hi});
                chk("sb_lo", {32'h0, lo_out}, {32'h0, e.lo});
                chk("sb_div_zero", {63'h0, div_zero}, {63'h0, e.dz});
            end
        end
        if (reset && div_zero && !done) begin
            checks++;
            failures++;
            $display("FAIL div_zero_without_done: got div_zero=1 done=0 expected both together");
        end
    end

    // Called at posedge+1. It returns at posedge+1 of the done cycle, or on timeout.
    task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         output int lat, output int bcnt, output logic b0);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = ed;
        sb_q.push_back(e);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        b0 = busy;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {63'h0, done}, 64'h1);
    endtask

    initial begin
        int     lat, bcnt, seen;
        logic   b0;
        logic   o;
        logic [31:0] ra, rb;
        logic [63:0] m;

        tbl[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[2] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[5] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[7] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[8] = '{1'b1, 32'h0000_0005, 32'h0000_0064, 32'h0000_0005, 32'h0000_0000, 1'b0};
        tbl[9] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};

        // Reset with random activity on every input
        reset = 1'b0;
        repeat (2) begin
            start = 1'b1; op = ~op; a = $urandom; b = $urandom;
            hi_wr = 1'b1; lo_wr = 1'b1; wr_data = $urandom;
            @(posedge clk); #1;
        end
        chk("reset_hi", {32'h0, hi_out}, 64'h0);
        chk("reset_lo", {32'h0, lo_out}, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        chk("reset_div_zero", {63'h0, div_zero}, 64'h0);
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, lat, bcnt, b0);
            chk("tbl_latency", 64'(lat), 64'd34);
            chk("tbl_busy_cycles", 64'(bcnt), 64'd33);
            @(posedge clk); #1;
        end

        // Randomized vectors from the behavioural model
        for (int i = 0; i < 8; i++) begin
            o  = (i % 2) == 1;
            ra = $urandom;
            rb = $urandom;
            if (o && rb == 32'h0) rb = 32'h1;
            m = model(o, ra, rb);
            issue(o, ra, rb, m[63:32], m[31:0], 1'b0, lat, bcnt, b0);
            chk("rand_latency", 64'(lat), 64'd34);
        end

        // Back-to-back DIVs: the second start is presented in the done cycle
        @(posedge clk); #1;
        issue(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, lat, bcnt, b0);
        chk("b2b_first_latency", 64'(lat), 64'd34);
        issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, lat, bcnt, b0);
        chk("b2b_second_busy_immediately", {63'h0, b0}, 64'h1);
        chk("b2b_second_latency", 64'(lat), 64'd34);
        @(posedge clk); #1;

        // Load HI/LO, then divide by zero
        hi_wr = 1'b1; wr_data = 32'h11;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 32'h22;
        @(posedge clk); #1;
        lo_wr = 1'b0;
        chk("mthi", {32'h0, hi_out}, 64'h11);
        chk("mtlo", {32'h0, lo_out}, 64'h22);
        issue(1'b1, 32'h1234, 32'h0, 32'h11, 32'h22, 1'b1, lat, bcnt, b0);
        chk("dz_latency", 64'(lat), 64'd1);
        chk("dz_busy_never", 64'(bcnt), 64'd0);
        @(posedge clk); #1;
        chk("dz_pulse_one_cycle", {62'h0, div_zero, done}, 64'h0);

        // MTHI/MTLO strobes while busy are ignored
        sb_q.push_back('{hi: 32'h0, lo: 32'd12, dz: 1'b0});
        op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h55;
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_wr_hi_ignored", {32'h0, hi_out}, 64'h11);
        chk("busy_wr_lo_ignored", {32'h0, lo_out}, 64'h22);
        hi_wr = 1'b0; lo_wr = 1'b0;
        wait_done("busy_wr_mult_done");
        @(posedge clk); #1;

        // Write coinciding with an accepted start: the write lands, then the result overwrites it
        sb_q.push_back('{hi: 32'h0, lo: 32'd6, dz: 1'b0});
        op = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1; hi_wr = 1'b1; wr_data = 32'h99;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0;
        chk("start_wr_hi", {32'h0, hi_out}, 64'h99);
        wait_done("start_wr_mult_done");
        @(posedge clk); #1;

        // Simultaneous MTHI and MTLO
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("both_wr_hi", {32'h0, hi_out}, 64'hA5A5_A5A5);
        chk("both_wr_lo", {32'h0, lo_out}, 64'hA5A5_A5A5);

        // Reset mid-operation discards the MULT, then the MULT is re-issued
        op = 1'b0; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_hi", {32'h0, hi_out}, 64'h0);
        chk("abort_lo", {32'h0, lo_out}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_activity", 64'(seen), 64'd0);
        issue(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, lat, bcnt, b0);
        chk("reissue_latency", 64'(lat), 64'd34);
        @(posedge clk); #1;

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer that owns the HI/LO register pair and runs MULT/DIV (signed, MIPS semantics) with one shared 32-iteration shift/add-subtract datapath.
- Sits beside the ALU in the multi-cycle CPU. control_unit issues start and holds in its execute state while busy is high, then advances when done pulses.
- Also services MTHI/MTLO writes, and supplies hi_out/lo_out to the MFHI/MFLO writeback mux.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled on the rising edge.
- op  input  1  0 = MULT, 1 = DIV; sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- hi_wr  input  1  MTHI strobe.
- lo_wr  input  1  MTLO strobe.
- wr_data  input  WIDTH  data for hi_wr / lo_wr.
- busy  output  1  operation in flight; start, hi_wr and lo_wr are ignored while high.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse, coincident with done, when DIV had b == 0.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.

Behaviour:
- Reset (reset == 0 at a rising edge) forces:
  - state = IDLE.
  - hi_out = 0, lo_out = 0.
  - busy = 0, done = 0, div_zero = 0.
  - counter = 0.
  - Reset wins over every other input.
  - Reset mid-operation discards the operation; no partial result reaches HI/LO.
- States: IDLE, MUL, DIV, FIX, DONE.
  - busy = 1 exactly in MUL, DIV and FIX.
  - done = 1 exactly in DONE.
- IDLE or DONE with start = 1:
  - Latch sign flags and operand magnitudes (two's-complement absolute value).
  - Clear the internal 2*WIDTH accumulator; counter = 0.
  - Go to MUL (op = 0) or DIV (op = 1).
  - Exception: DIV with b == 0 goes straight to DONE with div_zero = 1.
- IDLE or DONE with start = 0: DONE returns to IDLE; IDLE stays in IDLE.
- MUL: one shift-add step per cycle on the magnitudes (unsigned). After the counter reaches WIDTH-1, go to FIX.
- DIV: one restoring step per cycle (shift remainder left, trial subtract, set quotient bit). After the counter reaches WIDTH-1, go to FIX.
- FIX: apply signs and write HI/LO, then go to DONE.
  - MULT: {HI, LO} = signed 64-bit product; negate if sign(a) XOR sign(b).
  - DIV: LO = quotient truncated toward zero; negate if signs differ.
  - DIV: HI = remainder carrying the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps; no exception).
- Latency, counting the edge that samples start as edge 0:
  - HI/LO update at edge WIDTH+1 (33).
  - done is high during the cycle after edge WIDTH+1, i.e. 34 cycles after start is presented.
  - Divide-by-zero: done and div_zero are high in the cycle after edge 0; HI/LO are unchanged.
- start while busy is ignored with no queueing.
- start asserted in DONE is accepted: back-to-back operations with no idle cycle.
- hi_wr / lo_wr:
  - Take effect at the edge only in IDLE or DONE; ignored while busy.
  - If hi_wr or lo_wr coincides with an accepted start, the write happens and the operation later overwrites both registers.
  - If hi_wr and lo_wr are both set, both registers load wr_data.
- hi_out and lo_out hold their values between writes.
- The operands a and b are not required to remain stable after the start edge.

Test Plan:
- Reset: reset = 0 for 2 cycles with random inputs -> hi_out = lo_out = 0, busy = done = div_zero = 0.
- MULT: a = 7, b = 0xFFFFFFFD, start -> busy for 33 cycles, then done for 1 cycle with HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULT corner: a = b = 0x80000000 -> HI = 0x40000000, LO = 0x00000000.
- DIV and back-to-back:
  - a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Re-assert start with DIV a = 100, b = 7 in the done cycle -> next done gives LO = 14, HI = 2, with no IDLE cycle between the two operations.
- Divide-by-zero and ignored writes:
  - With HI = 0x11, LO = 0x22, issue DIV with b = 0 -> done and div_zero high in the next cycle, HI/LO unchanged.
  - Then hi_wr with wr_data = 0x55 during a later MULT -> ignored (HI keeps its pre-write value, then the MULT result).
- Abort and re-issue:
  - Start MULT 5 x 6; at cycle 10 pulse reset = 0 -> IDLE, HI/LO = 0, no done pulse.
  - Re-issue 5 x 6 -> HI = 0, LO = 30.
